// File: rtl/piso_stream_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piso_stream_serializer: valid/ready word-to-lane serializer with framing.
// Revision 1.0
// ----------------------------------------------------------------------------
module piso_stream_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [LANES-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CNT_W-1:0]      beat_cnt;
  logic [CNT_W-1:0]      beat_cnt_next;
  logic                  load;
  logic                  advance;
  logic                  finish;

  assign dout_valid = (state == SHIFT);
  assign busy       = dout_valid;
  assign dout_last  = dout_valid && (beat_cnt == LAST_CNT);
  // Ready during reset so the producer sees the block as empty immediately.
  assign din_ready  = reset || !dout_valid || (dout_ready && dout_last);

  assign load    = din_valid && din_ready;
  assign advance = dout_valid && dout_ready && !dout_last;
  assign finish  = dout_valid && dout_ready && dout_last;

  // shreg is cleared whenever idle, so dout is 0 without an explicit gate.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign dout = shreg[DATA_WIDTH-1 -: LANES];
    end else begin : g_lsb_first
      assign dout = shreg[LANES-1:0];
    end

    if (BEATS == 1) begin : g_single_beat
      assign shifted = '0;
    end else if (MSB_FIRST != 0) begin : g_shift_left
      assign shifted = {shreg[DATA_WIDTH-LANES-1:0], {LANES{1'b0}}};
    end else begin : g_shift_right
      assign shifted = {{LANES{1'b0}}, shreg[DATA_WIDTH-1:LANES]};
    end
  endgenerate

  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    beat_cnt_next = beat_cnt;
    if (load) begin
      // A load takes precedence over retiring the last beat in the same cycle.
      state_next    = SHIFT;
      shreg_next    = din;
      beat_cnt_next = '0;
    end else if (advance) begin
      shreg_next    = shifted;
      beat_cnt_next = beat_cnt + CNT_W'(1);
    end else if (finish) begin
      state_next    = IDLE;
      shreg_next    = '0;
      beat_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      beat_cnt <= beat_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_stream_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_piso_stream_serializer: table-driven checks over four serializer configs.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_piso_stream_serializer;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic        dout_ready;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        v0, v1, v2, v3;
  logic        l0, l1, l2, l3;
  logic        b0, b1, b2, b3;
  logic [0:0]  d0;
  logic [3:0]  d1, d2;
  logic [15:0] d3;

  // sel 0: 16/1 LSB-first, 1: 16/4 MSB-first, 2: 16/4 LSB-first, 3: 16/16
  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(1), .MSB_FIRST(0)) u_l1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy0),
    .dout(d0), .dout_valid(v0), .dout_ready(dout_ready), .dout_last(l0), .busy(b0));
  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(1)) u_l4m (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy1),
    .dout(d1), .dout_valid(v1), .dout_ready(dout_ready), .dout_last(l1), .busy(b1));
  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(0)) u_l4l (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy2),
    .dout(d2), .dout_valid(v2), .dout_ready(dout_ready), .dout_last(l2), .busy(b2));
  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(16), .MSB_FIRST(0)) u_l16 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy3),
    .dout(d3), .dout_valid(v3), .dout_ready(dout_ready), .dout_last(l3), .busy(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          sel_cur;
  logic        m_v, m_l, m_rdy, m_busy;
  logic [15:0] m_d;

  always_comb begin
    m_v = v0; m_l = l0; m_rdy = rdy0; m_busy = b0; m_d = 16'(d0);
    case (sel_cur)
      1: begin m_v = v1; m_l = l1; m_rdy = rdy1; m_busy = b1; m_d = 16'(d1); end
      2: begin m_v = v2; m_l = l2; m_rdy = rdy2; m_busy = b2; m_d = 16'(d2); end
      3: begin m_v = v3; m_l = l3; m_rdy = rdy3; m_busy = b3; m_d = d3; end
      default: ;
    endcase
  end

  typedef struct {
    int          sel;
    logic        chk;
    logic        rst;
    logic        dv;
    logic [15:0] din;
    logic        dr;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input int sel, input logic rst, input logic dv,
                              input logic [15:0] dw, input logic dr, input logic ev,
                              input logic [15:0] ed, input logic el, input logic erdy);
    vec_t v;
    v.sel = sel; v.chk = 1'b1; v.rst = rst; v.dv = dv; v.din = dw; v.dr = dr;
    v.ev = ev; v.ed = ed; v.el = el; v.erdy = erdy;
    vecs.push_back(v);
  endfunction

  // One unchecked reset cycle (other instances may be mid-word), then a checked one.
  function automatic void add_reset(input int sel);
    vec_t v;
    v.sel = sel; v.chk = 1'b0; v.rst = 1'b1; v.dv = 1'b0; v.din = '0; v.dr = 1'b1;
    v.ev = 1'b0; v.ed = '0; v.el = 1'b0; v.erdy = 1'b1;
    vecs.push_back(v);
    add(sel, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
  endfunction

  function automatic void add_idle(input int sel);
    add(sel, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
  endfunction

  initial begin
    logic [15:0] w;
    logic [15:0] w2;
    logic [15:0] exp_d;

    reset = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0; sel_cur = 0;

    // LSB-first single lane, 16'hA5C3
    w = 16'hA5C3;
    add_reset(0);
    add(0, 0, 1, w, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 16; i++)
      add(0, 0, 0, 16'h0, 1, 1, 16'(w[i]), (i == 15), (i == 15));
    add_idle(0);

    // MSB-first nibbles, 16'h1234 -> 1,2,3,4
    w = 16'h1234;
    add_reset(1);
    add(1, 0, 1, w, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 4; i++)
      add(1, 0, 0, 16'h0, 1, 1, 16'(w[15-4*i -: 4]), (i == 3), (i == 3));
    add_idle(1);

    // Back-to-back FFFF then 0001, LSB-first nibbles
    add_reset(2);
    add(2, 0, 1, 16'hFFFF, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 4; i++)
      add(2, 0, 1, 16'h0001, 1, 1, 16'hF, (i == 3), (i == 3));
    for (int i = 0; i < 4; i++)
      add(2, 0, 0, 16'h0, 1, 1, (i == 0) ? 16'h1 : 16'h0, (i == 3), (i == 3));
    add_idle(2);

    // Backpressure on beat 1 of 16'h00F0, with an ignored din_valid during the stall
    add_reset(2);
    add(2, 0, 1, 16'h00F0, 1, 0, 16'h0, 0, 1);
    add(2, 0, 0, 16'h0, 1, 1, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(2, 0, 1, 16'h1234, 0, 1, 16'hF, 0, 0);
    add(2, 0, 0, 16'h0, 1, 1, 16'hF, 0, 0);
    add(2, 0, 0, 16'h0, 1, 1, 16'h0, 0, 0);
    add(2, 0, 0, 16'h0, 1, 1, 16'h0, 1, 1);
    add_idle(2);

    // Reset at beat 5 of 16'hBEEF, then 16'h0003 from beat 0
    w  = 16'hBEEF;
    w2 = 16'h0003;
    add_reset(0);
    add(0, 0, 1, w, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 16'h0, 1, 1, 16'(w[i]), 0, 0);
    add(0, 1, 0, 16'h0, 1, 1, 16'(w[5]), 0, 1);
    add(0, 0, 1, w2, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 16; i++)
      add(0, 0, 0, 16'h0, 1, 1, 16'(w2[i]), (i == 15), (i == 15));
    add_idle(0);

    // Single-beat words with dout_ready 1,0,1,1
    add_reset(3);
    add(3, 0, 1, 16'h1111, 1, 0, 16'h0,    0, 1);
    add(3, 0, 1, 16'h2222, 1, 1, 16'h1111, 1, 1);
    add(3, 0, 1, 16'h3333, 0, 1, 16'h2222, 1, 0);
    add(3, 0, 1, 16'h3333, 1, 1, 16'h2222, 1, 1);
    add(3, 0, 1, 16'h4444, 1, 1, 16'h3333, 1, 1);
    add(3, 0, 0, 16'h0,    1, 1, 16'h4444, 1, 1);
    add_idle(3);

    repeat (2) @(negedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      sel_cur    = vecs[k].sel;
      reset      = vecs[k].rst;
      din_valid  = vecs[k].dv;
      din        = vecs[k].din;
      dout_ready = vecs[k].dr;
      #1;
      if (vecs[k].chk) begin
        n_tests++;
        if ({m_v, m_d, m_l, m_rdy, m_busy} !==
            {vecs[k].ev, vecs[k].ed, vecs[k].el, vecs[k].erdy, vecs[k].ev}) begin
          n_fail++;
          $display("FAIL vec%0d sel%0d: got v=%b d=%h last=%b rdy=%b busy=%b, want v=%b d=%h last=%b rdy=%b busy=%b",
                   k, vecs[k].sel, m_v, m_d, m_l, m_rdy, m_busy,
                   vecs[k].ev, vecs[k].ed, vecs[k].el, vecs[k].erdy, vecs[k].ev);
        end
      end
    end

    // Sustained throughput: 16'h4321 streamed continuously, LSB-first nibbles
    @(negedge clk);
    sel_cur = 2; reset = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; din_valid = 1'b1; din = 16'h4321;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      exp_d = 16'((i % 4) + 1);
      n_tests++;
      if (!(m_v === 1'b1 && m_d === exp_d && m_rdy === (i % 4 == 3) && m_l === (i % 4 == 3))) begin
        n_fail++;
        $display("FAIL stream beat%0d: got v=%b d=%h last=%b rdy=%b, want v=1 d=%h last=%b rdy=%b",
                 i, m_v, m_d, m_l, m_rdy, exp_d, (i % 4 == 3), (i % 4 == 3));
      end
    end
    din_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
